// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 device-side transmit queue.
//   state_e    : one-hot scheduler states
//   BAT_OK     : power-on self-test pass byte, also the reset value of the
//                "last successfully sent" register
//   RESEND_CMD : host resend command byte (decoded on the receive side)
package ps2_pkg;

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    LAUNCH    = 5'b00010,
    WAIT_BUSY = 5'b00100,
    WAIT_DONE = 5'b01000,
    GAP       = 5'b10000
  } state_e;

  localparam logic [7:0] BAT_OK     = 8'hAA;
  localparam logic [7:0] RESEND_CMD = 8'hFE;

endpackage

// File: rtl/ps2_tx_queue_if.sv
// ps2_tx_queue_if: upstream byte handshake plus transmitter-side handshake of
// the PS/2 transmit queue.
//   in_valid/in_data/in_ready : byte push from the scancode encoder
//   flush, resend_req         : queue discard / host resend request pulses
//   tx_ready/tx_finish/tx_abort : transmitter status
//   tx_start/tx_buffer        : launch pulse and byte to the transmitter
//   level, busy, err_drop     : status outputs
// master = encoder/transmitter side, slave = the queue.
interface ps2_tx_queue_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          flush;
  logic          resend_req;
  logic          tx_ready;
  logic          tx_finish;
  logic          tx_abort;
  logic          tx_start;
  logic [7:0]    tx_buffer;
  logic [LW-1:0] level;
  logic          busy;
  logic          err_drop;

  modport master (
    output in_valid, in_data, flush, resend_req, tx_ready, tx_finish, tx_abort,
    input  in_ready, tx_start, tx_buffer, level, busy, err_drop
  );

  modport slave (
    input  in_valid, in_data, flush, resend_req, tx_ready, tx_finish, tx_abort,
    output in_ready, tx_start, tx_buffer, level, busy, err_drop
  );
endinterface

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: show-ahead byte FIFO with synchronous flush.
//   clock_quarter, reset (sync, active-low), flush (empties next cycle)
//   push/din/full  : write side; pushes while full or flushing are ignored
//   pop/dout/empty : read side; dout is the current head
//   level          : occupancy, updated together with the pointers
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clock_quarter,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [7:0]               din,
  output logic                     full,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clock_quarter) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset: contents are only visible through level.
  always_ff @(posedge clock_quarter) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_tx_queue.sv
// ps2_tx_queue: schedules buffered scancode bytes into the PS/2 device-side
// transmitter with bounded retry on host abort, host resend and frame gap.
//   clock_quarter : quarter-bit clock shared with the transmitter
//   reset         : synchronous, active-low
//   q_if          : handshake bundle (slave side), see ps2_tx_queue_if
//
// state     | meaning
// IDLE      | waiting for a resend request or a queued byte with tx_ready
// LAUNCH    | tx_start high for one cycle, hold presented on tx_buffer
// WAIT_BUSY | waiting for the transmitter to drop tx_ready
// WAIT_DONE | frame on the wire; finish, abort or timeout
// GAP       | inter-frame idle time, then relaunch or return to IDLE
module ps2_tx_queue
  import ps2_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int MAX_RETRY  = 3,
  parameter int GAP_CYCLES = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic           clock_quarter,
  input  logic           reset,
  ps2_tx_queue_if.slave  q_if
);
  localparam int TMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE     = 1;
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [RW-1:0] R_ONE     = 1;

  state_e        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic [7:0]    last_sent_q, last_sent_d;
  logic          resend_pend_q, resend_pend_d;
  logic          retry_pend_q, retry_pend_d;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_drop_q, err_drop_d;
  logic          abort;

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;

  ps2_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock_quarter (clock_quarter),
    .reset         (reset),
    .flush         (q_if.flush),
    .push          (q_if.in_valid),
    .din           (q_if.in_data),
    .full          (fifo_full),
    .pop           (fifo_pop),
    .dout          (fifo_dout),
    .empty         (fifo_empty),
    .level         (q_if.level)
  );

  assign q_if.in_ready  = ~fifo_full;
  assign q_if.tx_start  = (state_q == LAUNCH);
  assign q_if.tx_buffer = hold_q;
  assign q_if.busy      = (state_q != IDLE);
  assign q_if.err_drop  = err_drop_q;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    last_sent_d   = last_sent_q;
    resend_pend_d = resend_pend_q | q_if.resend_req;
    retry_pend_d  = retry_pend_q;
    retry_cnt_d   = retry_cnt_q;
    timer_d       = timer_q;
    err_drop_d    = 1'b0;
    fifo_pop      = 1'b0;
    abort         = 1'b0;

    case (state_q)
      IDLE: begin
        if (q_if.tx_ready) begin
          if (resend_pend_q) begin
            hold_d        = last_sent_q;
            // A request arriving in the service cycle stays pending.
            resend_pend_d = q_if.resend_req;
            retry_cnt_d   = '0;
            state_d       = LAUNCH;
          end else if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            hold_d      = fifo_dout;
            retry_cnt_d = '0;
            state_d     = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
        timer_d = TO_LOAD;
      end
      WAIT_BUSY: begin
        if (!q_if.tx_ready) begin
          state_d = WAIT_DONE;
          timer_d = TO_LOAD;
        end else if (timer_q == '0) begin
          abort = 1'b1;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      WAIT_DONE: begin
        if (q_if.tx_abort || timer_q == '0) begin
          abort = 1'b1;
        end else if (q_if.tx_finish) begin
          last_sent_d = hold_q;
          state_d     = GAP;
          timer_d     = GAP_LOAD;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          if (retry_pend_q) begin
            retry_pend_d = 1'b0;
            state_d      = LAUNCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort from either wait state: retry while budget remains, else drop.
    if (abort) begin
      state_d = GAP;
      timer_d = GAP_LOAD;
      if (retry_cnt_q < RETRY_LIM) begin
        retry_cnt_d  = retry_cnt_q + R_ONE;
        retry_pend_d = 1'b1;
      end else begin
        err_drop_d   = 1'b1;
        retry_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_quarter) begin
    if (!reset) begin
      state_q       <= IDLE;
      hold_q        <= BAT_OK;
      last_sent_q   <= BAT_OK;
      resend_pend_q <= 1'b0;
      retry_pend_q  <= 1'b0;
      retry_cnt_q   <= '0;
      timer_q       <= '0;
      err_drop_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      last_sent_q   <= last_sent_d;
      resend_pend_q <= resend_pend_d;
      retry_pend_q  <= retry_pend_d;
      retry_cnt_q   <= retry_cnt_d;
      timer_q       <= timer_d;
      err_drop_q    <= err_drop_d;
    end
  end

endmodule
